hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and stall controller for the 5-stage MIPS pipeline. Combinationally computes forwarding selects, load-use and branch stalls, and the F/D/E/M/W stall and flush controls that drive the stage registers. Sequences multi-cycle data-memory waits with a wait-state FSM and timeout, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- TIMEOUT, 64: maximum consecutive memory-wait cycles before bus error; range 2..255.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- RsD, RtD  in  5 each  source registers of the instruction in D
- RsE, RtE  in  5 each  source registers of the instruction in E
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enable per stage
- MemtoRegE, MemtoRegM  in  1 each  instruction is a load
- BranchD  in  1  branch resolved in D
- MemReqM  in  1  load/store active in M
- MemReadyM  in  1  data memory completes the access this cycle
- StatClr  in  1  synchronous clear of StallCount
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register; the D register's Enable = ~StallD
- FlushE, FlushW  out  1 each  load a bubble into the E / W register
- ForwardAD, ForwardBD  out  1 each  D-stage comparator operand from M
- ForwardAE, ForwardBE  out  2 each  E-stage ALU operand select: 00 regfile, 01 W result, 10 M ALU result
- BusErr  out  1  sticky memory-timeout flag
- StallCount  out  CNT_W  saturating count of cycles with StallF=1

## Operation
- Forwarding (register 0 never matches):
  - ForwardAE=10 if RsE==WriteRegM & RegWriteM; else 01 if RsE==WriteRegW & RegWriteW; else 00. ForwardBE is the same with RtE. M has priority over W.
  - ForwardAD=1 if RsD!=0 & RsD==WriteRegM & RegWriteM. ForwardBD is the same with RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})).
- memstall = MemReqM & ~MemReadyM.
- Control priority, highest first:
  - ERR: StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0.
  - memstall: same outputs as ERR. It overrides lwstall and branchstall, so FlushE=0 and E is held, not bubbled.
  - lwstall | branchstall: StallF=StallD=FlushE=1; StallE=StallM=FlushW=0.
  - Otherwise: all stall and flush outputs are 0.
- FSM states: RUN, WAIT, ERR.
  - RUN → WAIT when memstall; WaitCnt←1.
  - WAIT with memstall: WaitCnt increments. When WaitCnt==TIMEOUT-1 and memstall still holds, go to ERR.
  - WAIT → RUN on the cycle MemReadyM=1, or when MemReqM drops.
  - ERR is absorbing; only reset exits it. BusErr=1 whenever state==ERR.
- StallCount increments on each cycle with StallF=1 and saturates at all-ones. StatClr=1 loads 0, and StatClr wins over an increment in the same cycle.
- WaitCnt is 8 bits and internal.

## Timing
- Reset (asynchronous, active-high):
  - State=RUN, WaitCnt=0, StallCount=0, BusErr=0.
  - While reset=1, all Stall*, Flush* and Forward* outputs are forced to 0.
- All stall, flush and forward outputs are combinational from the current inputs and state, with no added latency.
- A memory access with MemReadyM=1 in its first M cycle produces zero stall cycles.
- An access whose MemReadyM arrives N cycles late produces exactly N cycles of memstall. The instruction in W retires in the first of those cycles; every later stall cycle writes a bubble into W.
- Timeout: with MemReadyM held low from the RUN→WAIT cycle, ERR is entered TIMEOUT cycles after that transition. MemReadyM arriving in the same cycle that WaitCnt reaches TIMEOUT-1 completes the access normally, with no ERR.
- A reset asserted during WAIT or ERR returns to RUN immediately, without waiting for a clock edge.

## Test plan
- Forwarding: RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 → ForwardAE=10. Then RegWriteM=0 → 01. Then RsE=0 → 00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 for 1 cycle → StallF=StallD=FlushE=1 for exactly that cycle and StallCount increments by 1; next cycle all outputs 0.
- Branch hazard: BranchD=1, RegWriteE=1, WriteRegE=RtD=3 → StallF=StallD=FlushE=1. Then the result moves to M with MemtoRegM=0 and RegWriteM=1 → no stall, ForwardBD=1.
- Memory wait: MemReqM=1 with MemReadyM low for 3 cycles, then high → StallF..StallM=1 and FlushW=1 for 3 cycles with FlushE=0, back to RUN, StallCount=3; a concurrent lwstall does not raise FlushE.
- Timeout: TIMEOUT=4, MemReqM=1, MemReadyM=0 held → ERR entered 4 cycles after the RUN→WAIT transition with BusErr=1 and all stalls held. Asserting reset mid-cycle → BusErr=0, state=RUN, outputs 0 immediately.
- Saturation and clear: CNT_W=4 with 20 consecutive stall cycles → StallCount=15; StatClr=1 in a stall cycle → StallCount=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: forwarding selects,
// load-use/branch/memory stalls, a memory wait-state FSM with timeout, and a stall-cycle counter.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             StatClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             BusErr,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic lwstall, branchstall, memstall;

  function automatic logic [1:0] fwd_e(input logic [4:0] src, input logic [4:0] wr_m,
                                       input logic rw_m, input logic [4:0] wr_w,
                                       input logic rw_w);
    if (src != 5'd0 && rw_m && src == wr_m)      return 2'b10;
    else if (src != 5'd0 && rw_w && src == wr_w) return 2'b01;
    else                                         return 2'b00;
  endfunction

  always_comb begin
    lwstall     = MemtoRegE && (RtE == RsD || RtE == RtD);
    branchstall = BranchD &&
                  ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                   (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    memstall    = MemReqM && !MemReadyM;
  end

  // A memory wait holds E instead of bubbling it, so it must outrank load-use/branch stalls.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_e(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
      ForwardBE = fwd_e(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
      ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
      ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);
      if (state_q == ERR || memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (lwstall || branchstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      RUN: begin
        if (memstall) begin
          state_d    = WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      WAIT: begin
        if (!memstall) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR:     bus_err_d = 1'b1;
      default: state_d   = RUN;
    endcase
  end

  // Clear takes precedence over counting so software reads a clean zero.
  always_comb begin
    stall_count_d = stall_count_q;
    if (StatClr)
      stall_count_d = '0;
    else if (StallF && !(&stall_count_q))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      bus_err_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      bus_err_q     <= bus_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign BusErr     = bus_err_q;
  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, MemReqM, MemReadyM, StatClr;
  logic StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic BusErr;
  logic [CNT_W-1:0] StallCount;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .StatClr(StatClr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .BusErr(BusErr), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: sticky error, run length of consecutive memory-stall cycles, stall counter.
  bit   m_err;
  int   m_consec;
  int   m_cnt;
  bit   ms_now;
  logic [5:0] e_ctl;
  logic [1:0] e_fae, e_fbe;
  logic e_fad, e_fbd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_err    = 1'b0;
    m_consec = 0;
    m_cnt    = 0;
  endtask

  function automatic logic [1:0] fwd_sel(input int src, input int wm, input bit rwm,
                                         input int ww, input bit rww);
    if (src != 0 && rwm && src == wm) return 2'd2;
    if (src != 0 && rww && src == ww) return 2'd1;
    return 2'd0;
  endfunction

  task automatic predict();
    bit lw, br;
    lw = MemtoRegE && (RtE == RsD || RtE == RtD);
    br = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                     (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
    ms_now = MemReqM && !MemReadyM;
    e_ctl = 6'b000000;
    e_fae = 2'd0; e_fbe = 2'd0; e_fad = 1'b0; e_fbd = 1'b0;
    if (!reset) begin
      if (m_err || ms_now) e_ctl = 6'b111101;
      else if (lw || br)   e_ctl = 6'b110010;
      e_fae = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
      e_fbe = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
      e_fad = RsD != 0 && RegWriteM && RsD == WriteRegM;
      e_fbd = RtD != 0 && RegWriteM && RtD == WriteRegM;
    end
  endtask

  task automatic advance_model();
    if (reset) begin
      model_reset();
    end else begin
      if (StatClr) m_cnt = 0;
      else if (e_ctl[5] && m_cnt < CNT_MAX) m_cnt++;
      if (!m_err) begin
        m_consec = ms_now ? m_consec + 1 : 0;
        if (m_consec >= TIMEOUT) m_err = 1'b1;
      end
    end
  endtask

  task automatic clear_inputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
    {BranchD, MemReqM, MemReadyM, StatClr} = '0;
  endtask

  // Compare combinational outputs mid-cycle, then registered state just after the edge.
  task automatic check_cycle(input string tag);
    @(negedge clk);
    predict();
    check({tag, ".ctl"}, 32'({StallF, StallD, StallE, StallM, FlushE, FlushW}), 32'(e_ctl));
    check({tag, ".fae"}, 32'(ForwardAE), 32'(e_fae));
    check({tag, ".fbe"}, 32'(ForwardBE), 32'(e_fbe));
    check({tag, ".fd"},  32'({ForwardAD, ForwardBD}), 32'({e_fad, e_fbd}));
    check({tag, ".err"}, 32'(BusErr), reset ? 32'd0 : 32'(m_err));
    advance_model();
    @(posedge clk);
    #1;
    check({tag, ".cnt"}, 32'(StallCount), 32'(m_cnt));
    check({tag, ".err2"}, 32'(BusErr), 32'(m_err));
  endtask

  initial begin
    model_reset();
    clear_inputs();
    reset = 1'b1;
    RsE = 5'd5; WriteRegM = 5'd5; RegWriteM = 1'b1; MemReqM = 1'b1; MemtoRegE = 1'b1;
    #2;
    check("rst_out", 32'({StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAE}), 32'd0);
    check_cycle("rst");
    reset = 1'b0;
    clear_inputs();

    RsE = 5'd5; WriteRegM = 5'd5; RegWriteM = 1'b1; WriteRegW = 5'd5; RegWriteW = 1'b1;
    check_cycle("fwd_m");
    check("fwd_m_const", 32'(ForwardAE), 32'd2);
    RegWriteM = 1'b0;
    check_cycle("fwd_w");
    check("fwd_w_const", 32'(ForwardAE), 32'd1);
    RsE = 5'd0;
    check_cycle("fwd_0");
    check("fwd_0_const", 32'(ForwardAE), 32'd0);
    clear_inputs();

    MemtoRegE = 1'b1; RtE = 5'd8; RsD = 5'd8;
    check_cycle("lu");
    check("lu_cnt", 32'(StallCount), 32'd1);
    clear_inputs();
    check_cycle("lu_after");

    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3; RtD = 5'd3;
    check_cycle("br_e");
    RegWriteE = 1'b0; WriteRegE = 5'd0; WriteRegM = 5'd3; RegWriteM = 1'b1;
    check_cycle("br_m");
    check("br_m_fbd", 32'({ForwardBD, StallF}), 32'b10);
    clear_inputs();

    StatClr = 1'b1;
    check_cycle("clr");
    StatClr = 1'b0;
    MemReqM = 1'b1;
    check_cycle("mw0");
    MemtoRegE = 1'b1; RtE = 5'd7; RsD = 5'd7;
    check_cycle("mw1_lw");
    check("mw1_flushE", 32'({FlushE, FlushW}), 32'b01);
    MemtoRegE = 1'b0; RtE = 5'd0; RsD = 5'd0;
    check_cycle("mw2");
    MemReadyM = 1'b1;
    check_cycle("mw_done");
    check("mw_cnt", 32'(StallCount), 32'd3);
    clear_inputs();

    MemtoRegE = 1'b1; RtE = 5'd9; RtD = 5'd9;
    for (int i = 0; i < 20; i++) check_cycle("sat");
    check("sat_cnt", 32'(StallCount), 32'd15);
    StatClr = 1'b1;
    check_cycle("sat_clr");
    check("sat_clr_cnt", 32'(StallCount), 32'd0);
    clear_inputs();

    MemReqM = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) check_cycle("late_ok");
    MemReadyM = 1'b1;
    check_cycle("late_ok_rdy");
    check("late_ok_err", 32'(BusErr), 32'd0);
    clear_inputs();

    MemReqM = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) check_cycle("to");
    check("to_err", 32'(BusErr), 32'd1);
    MemReqM = 1'b0;
    check_cycle("to_hold");
    RsE = 5'd2; WriteRegM = 5'd2; RegWriteM = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("to_rst_out", 32'({StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAE}), 32'd0);
    check("to_rst_err", 32'({BusErr, StallCount}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_inputs();
    check_cycle("post_rst");

    for (int i = 0; i < 400; i++) begin
      RsD = 5'($urandom_range(0, 3));       RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3));       RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom);  RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom);  MemtoRegM = 1'($urandom); BranchD = 1'($urandom);
      MemReqM   = ($urandom_range(0, 2) == 0);
      MemReadyM = 1'($urandom);
      StatClr   = ($urandom_range(0, 15) == 0);
      reset     = m_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
      check_cycle("rnd");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
